// File: rtl/multicycle_main_control_pkg.sv
// Shared constants for the multicycle MIPS main control: opcodes, ALUOp codes,
// state encoding and the bundled control-word type.
package multicycle_main_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
  } ctrl_t;

  // States that wait on the memory handshake and are covered by the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
  endfunction

endpackage

// File: rtl/multicycle_main_control_mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags a timeout
// when the count reaches MEM_WAIT_MAX with the memory still not ready.
module mem_wait_timer #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  input  logic clear,
  output logic timeout
);

  localparam logic [WAIT_CNT_W-1:0] CNT_MAX = WAIT_CNT_W'(MEM_WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE = WAIT_CNT_W'(1);

  logic [WAIT_CNT_W-1:0] wait_cnt_r;

  assign timeout = active & ~ready & (wait_cnt_r == CNT_MAX);

  // Wait counter; a timeout restarts it even when the state does not change.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (clear || timeout || !active || ready) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + CNT_ONE;
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath selects and enables, and times out slow memory.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int WAIT_CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALU_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_out
);

  state_t state_r, next_state_s;
  ctrl_t  ctrl_s, ctrl_out_s;
  logic   timeout_s, active_s, clear_s;

  assign active_s = is_mem_state(state_r);
  assign clear_s  = (next_state_s != state_r);

  mem_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .WAIT_CNT_W  (WAIT_CNT_W)
  ) u_mem_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .active (active_s),
    .ready  (mem_ready),
    .clear  (clear_s),
    .timeout(timeout_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and Moore control decode; strobes are suppressed on a timeout.
  always_comb begin
    ctrl_s       = '0;
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_read  = ~timeout_s;
        ctrl_s.alu_src_b = 2'b01;
        ctrl_s.alu_op    = ALUOP_ADD;
        ctrl_s.ir_write  = mem_ready;
        ctrl_s.pc_write  = mem_ready;
        ctrl_s.bus_error = timeout_s;
        next_state_s     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctrl_s.alu_src_b = 2'b11;
        ctrl_s.alu_op    = ALUOP_ADD;
        case (opcode)
          OP_RTYPE:     next_state_s = S_R_EXEC;
          OP_LW, OP_SW: next_state_s = S_MEM_ADDR;
          OP_BEQ:       next_state_s = S_BRANCH;
          OP_ADDI:      next_state_s = S_ADDI_EXEC;
          OP_J:         next_state_s = S_JUMP;
          default: begin
            ctrl_s.illegal_op = 1'b1;
            next_state_s      = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b10;
        ctrl_s.alu_op    = ALUOP_ADD;
        if (opcode == OP_LW) begin
          next_state_s = S_MEM_READ;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEM_WRITE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_MEM_READ: begin
        ctrl_s.mem_read  = ~timeout_s;
        ctrl_s.i_or_d    = 1'b1;
        ctrl_s.bus_error = timeout_s;
        if (mem_ready) begin
          next_state_s = S_MEM_WB;
        end else if (timeout_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_READ;
        end
      end
      S_MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_s.mem_write  = ~timeout_s;
        ctrl_s.i_or_d     = 1'b1;
        ctrl_s.instr_done = mem_ready;
        ctrl_s.bus_error  = timeout_s;
        if (mem_ready || timeout_s) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WRITE;
        end
      end
      S_R_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b00;
        ctrl_s.alu_op    = ALUOP_FUNCT;
        next_state_s     = S_R_WB;
      end
      S_R_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a  = 1'b1;
        ctrl_s.alu_op     = ALUOP_SUB;
        ctrl_s.pc_src     = 2'b01;
        ctrl_s.pc_write   = zero;
        ctrl_s.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = 2'b10;
        ctrl_s.alu_op    = ALUOP_ADD;
        next_state_s     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_s.pc_src     = 2'b10;
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      default: begin
        ctrl_s       = '0;
        next_state_s = S_FETCH;
      end
    endcase
  end

  // Reset blanks every output, including the debug state view.
  assign ctrl_out_s = rst ? '0 : ctrl_s;
  assign state_out  = rst ? 4'd0 : state_r;

  assign ALU_op     = ctrl_out_s.alu_op;
  assign alu_src_a  = ctrl_out_s.alu_src_a;
  assign alu_src_b  = ctrl_out_s.alu_src_b;
  assign pc_src     = ctrl_out_s.pc_src;
  assign pc_write   = ctrl_out_s.pc_write;
  assign i_or_d     = ctrl_out_s.i_or_d;
  assign mem_read   = ctrl_out_s.mem_read;
  assign mem_write  = ctrl_out_s.mem_write;
  assign ir_write   = ctrl_out_s.ir_write;
  assign reg_dst    = ctrl_out_s.reg_dst;
  assign mem_to_reg = ctrl_out_s.mem_to_reg;
  assign reg_write  = ctrl_out_s.reg_write;
  assign instr_done = ctrl_out_s.instr_done;
  assign illegal_op = ctrl_out_s.illegal_op;
  assign bus_error  = ctrl_out_s.bus_error;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed scenarios then random traffic,
// checked each cycle against an instruction-plan reference model.
module tb_multicycle_main_control;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state;
  } view_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [1:0] ALU_op, alu_src_b, pc_src;
  logic       alu_src_a, pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, bus_error;
  logic [3:0] state_out;

  int errors = 0;
  int checks = 0;
  int plan[$];
  int waits = 0;

  multicycle_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALU_op(ALU_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_write(pc_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_op(illegal_op), .bus_error(bus_error),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Expected outputs for the step the model is on, given this cycle's inputs.
  function automatic view_t model_expect(input logic r, input int k, input int w,
                                         input logic [5:0] op, input logic z,
                                         input logic rdy);
    view_t v;
    logic  abort;
    v = '0;
    if (r) return v;
    abort   = (k == 0 || k == 3 || k == 5) && !rdy && (w == WAIT_MAX);
    v.state = 4'(k);
    case (k)
      0: begin v.mem_read = !abort; v.src_b = 2'b01; v.ir_write = rdy;
               v.pc_write = rdy; v.bus_error = abort; end
      1: begin v.src_b = 2'b11;
               v.illegal_op = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                           6'b000100, 6'b001000, 6'b000010}); end
      2: begin v.src_a = 1'b1; v.src_b = 2'b10; end
      3: begin v.mem_read = !abort; v.i_or_d = 1'b1; v.bus_error = abort; end
      4: begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.instr_done = 1'b1; end
      5: begin v.mem_write = !abort; v.i_or_d = 1'b1; v.instr_done = rdy;
               v.bus_error = abort; end
      6: begin v.src_a = 1'b1; v.alu_op = 2'b10; end
      7: begin v.reg_write = 1'b1; v.reg_dst = 1'b1; v.instr_done = 1'b1; end
      8: begin v.src_a = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01;
               v.pc_write = z; v.instr_done = 1'b1; end
      9: begin v.src_a = 1'b1; v.src_b = 2'b10; end
      10: begin v.reg_write = 1'b1; v.instr_done = 1'b1; end
      11: begin v.pc_src = 2'b10; v.pc_write = 1'b1; v.instr_done = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Advance the model: decode lays out the whole instruction's step list.
  task automatic model_advance(input logic r, input logic [5:0] op, input logic rdy);
    int k;
    if (r) begin
      plan = {0};
      waits = 0;
      return;
    end
    k = plan[0];
    if ((k == 0 || k == 3 || k == 5) && !rdy) begin
      if (waits == WAIT_MAX) begin
        plan = {0};
        waits = 0;
      end else begin
        waits++;
      end
      return;
    end
    waits = 0;
    void'(plan.pop_front());
    if (k == 0) plan.push_back(1);
    else if (k == 1) begin
      case (op)
        6'b000000: plan = {6, 7};
        6'b100011: plan = {2, 3, 4};
        6'b101011: plan = {2, 5};
        6'b000100: plan = {8};
        6'b001000: plan = {9, 10};
        6'b000010: plan = {11};
        default:   plan = {};
      endcase
    end
    if (plan.size() == 0) plan.push_back(0);
  endtask

  task automatic cyc(input string tag, input logic r, input logic [5:0] op,
                     input logic z, input logic rdy);
    view_t obs, exp_v;
    @(negedge clk);
    rst = r; opcode = op; zero = z; mem_ready = rdy;
    #1;
    exp_v = model_expect(r, plan[0], waits, op, z, rdy);
    obs = {ALU_op, alu_src_a, alu_src_b, pc_src, pc_write, i_or_d, mem_read,
           mem_write, ir_write, reg_dst, mem_to_reg, reg_write, instr_done,
           illegal_op, bus_error, state_out};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (state obs=%0d exp=%0d)",
             tag, obs, exp_v, obs.state, exp_v.state);
    end
    model_advance(r, op, rdy);
  endtask

  initial begin
    logic [5:0] cur_op;
    logic [5:0] ops[7];
    int burst;
    logic rdy, r;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    plan = {0};

    for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 6'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc("rtype", 1'b0, 6'b000000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("lw_front", 1'b0, 6'b100011, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("lw_wait", 1'b0, 6'b100011, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("lw_done", 1'b0, 6'b100011, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("sw_front", 1'b0, 6'b101011, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("sw_wait", 1'b0, 6'b101011, 1'b0, 1'b0);
    cyc("sw_done", 1'b0, 6'b101011, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("beq_taken", 1'b0, 6'b000100, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("beq_not_taken", 1'b0, 6'b000100, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc("illegal", 1'b0, 6'b111111, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cyc("fetch_timeout", 1'b0, 6'b001000, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) cyc("fetch_slow", 1'b0, 6'b001000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("ready_wins_addi", 1'b0, 6'b001000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("jump", 1'b0, 6'b000010, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("lw_front2", 1'b0, 6'b100011, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cyc("read_timeout", 1'b0, 6'b100011, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("rst_mid", 1'b0, 6'b000000, 1'b0, 1'b1);
    cyc("rst_mid", 1'b1, 6'b000000, 1'b0, 1'b1);

    cur_op = 6'd0;
    burst = 0;
    for (int n = 0; n < 4000; n++) begin
      if (plan[0] == 0) begin
        cur_op = ops[$urandom_range(0, 6)];
        if ($urandom_range(0, 15) == 0) cur_op = 6'($urandom_range(0, 63));
      end
      if (burst > 0) begin
        rdy = 1'b0;
        burst--;
      end else if ($urandom_range(0, 60) == 0) begin
        burst = $urandom_range(12, 20);
        rdy = 1'b0;
      end else begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      r = ($urandom_range(0, 250) == 0);
      cyc("random", r, cur_op, 1'($urandom_range(0, 1)), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
